// File: rtl/mem_port_arbiter_if.sv
// Bundle of the IF/LSU request-done handshakes and the memory req/ready bus.
// slave modport: arbiter view; master modport: requesters + memory view.
// No storage of its own; timing is set entirely by the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              lsu_req;
  logic              lsu_we;
  logic [ADDR_W-1:0] lsu_addr;
  logic [DATA_W-1:0] lsu_wdata;
  logic [2:0]        lsu_width;
  logic              lsu_done;
  logic [DATA_W-1:0] lsu_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_width;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_width,
           mem_ready, mem_rdata,
    output if_done, if_rdata, lsu_done, lsu_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_width, busy
  );

  modport master (
    output if_req, if_addr, lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_width,
           mem_ready, mem_rdata,
    input  if_done, if_rdata, lsu_done, lsu_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_width, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and the LSU (LSU priority, IF anti-starvation).
// Latency: req sampled cycle 0, mem_req cycle 1, ready cycle k, done cycle k+1; one transaction per 3 cycles at best.
// Backpressure: requests wait while busy; memory stalls by holding mem_ready low. Optional stats via MEM_ARB_STATS_EN.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] if_grant_cnt,
  output logic [31:0] lsu_grant_cnt,
  output logic [31:0] if_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, MEM_IF, MEM_LSU, RESP} state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t            state;
  state_t            state_next;
  logic              grant_if;
  logic              grant_lsu;
  logic              mem_done;
  logic              resp_lsu;
  logic [3:0]        wait_cnt;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [2:0]        mem_width_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] lsu_rdata_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and grant choice: LSU wins unless IF has already waited MAX_WAIT LSU grants.
  always_comb begin
    state_next = state;
    grant_if   = 1'b0;
    grant_lsu  = 1'b0;
    mem_done   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.lsu_req && (!bus.if_req || (wait_cnt < MAX_WAIT_C))) begin
          grant_lsu  = 1'b1;
          state_next = MEM_LSU;
        end else if (bus.if_req) begin
          grant_if   = 1'b1;
          state_next = MEM_IF;
        end
      end
      MEM_IF, MEM_LSU: begin
        if (bus.mem_ready) begin
          mem_done   = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the winner's attributes on grant, track IF waiting, capture read data on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_width_q <= 3'b000;
      resp_lsu    <= 1'b0;
      wait_cnt    <= 4'd0;
      if_rdata_q  <= '0;
      lsu_rdata_q <= '0;
    end else begin
      if (grant_lsu) begin
        mem_we_q    <= bus.lsu_we;
        mem_addr_q  <= bus.lsu_addr;
        mem_wdata_q <= bus.lsu_wdata;
        mem_width_q <= bus.lsu_width;
        resp_lsu    <= 1'b1;
        if (!bus.if_req) begin
          wait_cnt <= 4'd0;
        end else if (wait_cnt != MAX_WAIT_C) begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end else if (grant_if) begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= bus.if_addr;
        mem_wdata_q <= '0;
        mem_width_q <= 3'b010;
        resp_lsu    <= 1'b0;
        wait_cnt    <= 4'd0;
      end
      // Stores complete without touching lsu_rdata.
      if (mem_done && (state == MEM_IF)) begin
        if_rdata_q <= bus.mem_rdata;
      end
      if (mem_done && (state == MEM_LSU) && !mem_we_q) begin
        lsu_rdata_q <= bus.mem_rdata;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Wrapping grant and IF stall counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_grant_cnt  <= 32'd0;
      lsu_grant_cnt <= 32'd0;
      if_stall_cnt  <= 32'd0;
    end else begin
      if (grant_if) begin
        if_grant_cnt <= if_grant_cnt + 32'd1;
      end
      if (grant_lsu) begin
        lsu_grant_cnt <= lsu_grant_cnt + 32'd1;
      end
      if (bus.if_req && !bus.if_done) begin
        if_stall_cnt <= if_stall_cnt + 32'd1;
      end
    end
  end
`endif

  // mem_req is a pure decode of the MEM states, so it can never be high in IDLE or RESP.
  assign bus.mem_req   = (state == MEM_IF) || (state == MEM_LSU);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_width = mem_width_q;
  assign bus.if_done   = (state == RESP) && !resp_lsu;
  assign bus.lsu_done  = (state == RESP) && resp_lsu;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.lsu_rdata = lsu_rdata_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
// Inputs are driven and outputs sampled on the falling clock edge.
// Optional counters are exercised when MEM_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_ARB_STATS_EN
  logic [31:0] if_grant_cnt;
  logic [31:0] lsu_grant_cnt;
  logic [31:0] if_stall_cnt;
`endif

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .if_grant_cnt(if_grant_cnt),
    .lsu_grant_cnt(lsu_grant_cnt),
    .if_stall_cnt(if_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Transaction-level reference model state.
  bit          if_out, lsu_out, in_txn, cur_lsu, exp_done, prev_busy;
  int          wait_m, mem_dly;
  logic [31:0] exp_if_rd, exp_lsu_rd;
  logic        t_we;
  logic [2:0]  t_w;
  logic [31:0] t_a, t_wd;
  bit          grant_log[$];
  logic [31:0] mem_m [bit [31:0]];

  function automatic logic [31:0] mem_rd(logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic cy();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.lsu_addr = '0; bus.lsu_wdata = '0; bus.lsu_width = 3'b000;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cy();
    cy();
    rst = 1'b0;
    if_out = 0; lsu_out = 0; in_txn = 0; cur_lsu = 0; exp_done = 0; prev_busy = 0;
    wait_m = 0; mem_dly = 0; exp_if_rd = '0; exp_lsu_rd = '0;
    mem_m.delete();
    grant_log.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.if_req = 1'b1; bus.lsu_req = 1'b1; bus.mem_ready = 1'b1; bus.lsu_addr = 32'hFFFF_FFF0;
    cy();
    cy();
    total++;
    if ({bus.mem_req, bus.mem_we, bus.if_done, bus.lsu_done, bus.busy} !== 5'b00000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {bus.mem_req, bus.mem_we, bus.if_done, bus.lsu_done, bus.busy});
    end
    total++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_width} !== {32'h0, 32'h0, 3'b000}) begin
      bad++; $display("FAIL reset_mem_bus: addr=%h wdata=%h width=%b want zeros", bus.mem_addr, bus.mem_wdata, bus.mem_width);
    end
    total++;
    if ({bus.if_rdata, bus.lsu_rdata} !== 64'h0) begin
      bad++; $display("FAIL reset_rdata: if=%h lsu=%h want 0", bus.if_rdata, bus.lsu_rdata);
    end
`ifdef MEM_ARB_STATS_EN
    total++;
    if ({if_grant_cnt, lsu_grant_cnt, if_stall_cnt} !== 96'h0) begin
      bad++; $display("FAIL reset_stats: %0d %0d %0d want 0 0 0", if_grant_cnt, lsu_grant_cnt, if_stall_cnt);
    end
`endif
  endtask

  task automatic test_single_fetch();
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h100;
    cy();
    total++;
    if ({bus.mem_req, bus.mem_we, bus.mem_width, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b0, 3'b010, 32'h100, 32'h0}) begin
      bad++; $display("FAIL fetch_issue: req=%b we=%b w=%b addr=%h wd=%h want 1 0 010 100 0",
                      bus.mem_req, bus.mem_we, bus.mem_width, bus.mem_addr, bus.mem_wdata);
    end
    cy();
    total++;
    if ({bus.mem_req, bus.if_done, bus.mem_addr} !== {2'b10, 32'h100}) begin
      bad++; $display("FAIL fetch_hold: req=%b done=%b addr=%h want 1 0 100", bus.mem_req, bus.if_done, bus.mem_addr);
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
    cy();
    total++;
    if ({bus.if_done, bus.lsu_done, bus.mem_req, bus.if_rdata} !== {3'b100, 32'hCAFE_0001}) begin
      bad++; $display("FAIL fetch_done: if_done=%b lsu_done=%b mem_req=%b rdata=%h want 1 0 0 cafe0001",
                      bus.if_done, bus.lsu_done, bus.mem_req, bus.if_rdata);
    end
    bus.if_req = 1'b0; bus.mem_ready = 1'b0; bus.mem_rdata = 32'h0BAD_0BAD;
    cy();
    total++;
    if ({bus.if_done, bus.busy, bus.if_rdata} !== {2'b00, 32'hCAFE_0001}) begin
      bad++; $display("FAIL fetch_pulse: done=%b busy=%b rdata=%h want 0 0 cafe0001", bus.if_done, bus.busy, bus.if_rdata);
    end
  endtask

  task automatic test_store();
    do_reset();
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b1; bus.lsu_addr = 32'h200; bus.lsu_wdata = 32'hDEAD_BEEF;
    bus.lsu_width = 3'b000; bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
    cy();
    total++;
    if ({bus.mem_req, bus.mem_we, bus.mem_width, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 3'b000, 32'h200, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL store_issue: req=%b we=%b w=%b addr=%h wd=%h want 1 1 000 200 deadbeef",
                      bus.mem_req, bus.mem_we, bus.mem_width, bus.mem_addr, bus.mem_wdata);
    end
    cy();
    total++;
    if ({bus.lsu_done, bus.if_done, bus.mem_req, bus.lsu_rdata} !== {3'b100, 32'h0}) begin
      bad++; $display("FAIL store_done: lsu_done=%b if_done=%b mem_req=%b lsu_rdata=%h want 1 0 0 0",
                      bus.lsu_done, bus.if_done, bus.mem_req, bus.lsu_rdata);
    end
    bus.lsu_req = 1'b0; bus.mem_ready = 1'b0;
    cy();
    total++;
    if ({bus.lsu_done, bus.busy} !== 2'b00) begin
      bad++; $display("FAIL store_pulse: done=%b busy=%b want 0 0", bus.lsu_done, bus.busy);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = 32'h400; bus.lsu_width = 3'b010;
    bus.mem_ready = 1'b1;
    cy();
    total++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h400}) begin
      bad++; $display("FAIL simul_lsu_first: req=%b we=%b addr=%h want 1 0 400", bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    bus.mem_rdata = 32'h400 ^ 32'h5A5A_5A5A;
    cy();
    total++;
    if ({bus.lsu_done, bus.if_done, bus.lsu_rdata} !== {2'b10, 32'h400 ^ 32'h5A5A_5A5A}) begin
      bad++; $display("FAIL simul_lsu_done: lsu_done=%b if_done=%b rdata=%h", bus.lsu_done, bus.if_done, bus.lsu_rdata);
    end
    bus.lsu_req = 1'b0;
    cy();
    total++;
    if ({bus.busy, bus.mem_req, bus.if_done} !== 3'b000) begin
      bad++; $display("FAIL simul_gap: busy=%b req=%b if_done=%b want 000", bus.busy, bus.mem_req, bus.if_done);
    end
    cy();
    total++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_width} !== {1'b1, 32'h300, 3'b010}) begin
      bad++; $display("FAIL simul_if_next: req=%b addr=%h w=%b want 1 300 010", bus.mem_req, bus.mem_addr, bus.mem_width);
    end
    bus.mem_rdata = 32'h300 ^ 32'h5A5A_5A5A;
    cy();
    total++;
    if ({bus.if_done, bus.lsu_done, bus.if_rdata} !== {2'b10, 32'h300 ^ 32'h5A5A_5A5A}) begin
      bad++; $display("FAIL simul_if_done: if_done=%b lsu_done=%b rdata=%h", bus.if_done, bus.lsu_done, bus.if_rdata);
    end
    bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    cy();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h500;
    cy();
    total++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h500}) begin
      bad++; $display("FAIL rstmid_issue: req=%b addr=%h want 1 500", bus.mem_req, bus.mem_addr);
    end
    rst = 1'b1;
    cy();
    total++;
    if ({bus.mem_req, bus.busy, bus.if_done, bus.lsu_done, bus.mem_addr} !== {4'b0000, 32'h0}) begin
      bad++; $display("FAIL rstmid_abandon: req=%b busy=%b if_done=%b lsu_done=%b addr=%h want 0 0 0 0 0",
                      bus.mem_req, bus.busy, bus.if_done, bus.lsu_done, bus.mem_addr);
    end
    rst = 1'b0; bus.if_addr = 32'h504;
    cy();
    total++;
    if ({bus.if_done, bus.mem_req, bus.mem_addr} !== {2'b01, 32'h504}) begin
      bad++; $display("FAIL rstmid_reissue: done=%b req=%b addr=%h want 0 1 504", bus.if_done, bus.mem_req, bus.mem_addr);
    end
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77;
    cy();
    total++;
    if ({bus.if_done, bus.lsu_done, bus.if_rdata} !== {2'b10, 32'h77}) begin
      bad++; $display("FAIL rstmid_done: if_done=%b lsu_done=%b rdata=%h want 1 0 77", bus.if_done, bus.lsu_done, bus.if_rdata);
    end
    bus.if_req = 1'b0; bus.mem_ready = 1'b0;
    cy();
  endtask

  // Drives random requesters and a random-latency memory; checks every cycle against the model.
  task automatic run_traffic(int ncyc, int p_if, int p_lsu, bit drops);
    bit issue, lsu_win, done_now;
    prev_busy = bus.busy;
    for (int c = 0; c < ncyc + 300; c++) begin
      issue = (c < ncyc);
      if (!issue && !if_out && !lsu_out && !in_txn) break;
      cy();
      // Arbitration decision taken at the edge just passed, using the requests held then.
      if (!prev_busy) begin
        total++;
        if (bus.mem_req !== (bus.if_req | bus.lsu_req)) begin
          bad++; $display("FAIL rt_grant_taken: mem_req=%b if_req=%b lsu_req=%b", bus.mem_req, bus.if_req, bus.lsu_req);
        end
        if (bus.if_req | bus.lsu_req) begin
          lsu_win = bus.lsu_req && (!bus.if_req || (wait_m < MAX_WAIT));
          if (lsu_win) wait_m = bus.if_req ? ((wait_m < MAX_WAIT) ? wait_m + 1 : MAX_WAIT) : 0;
          else wait_m = 0;
          cur_lsu = lsu_win; in_txn = 1; mem_dly = $urandom_range(0, 3);
          grant_log.push_back(lsu_win);
          t_we = lsu_win ? bus.lsu_we : 1'b0;
          t_w  = lsu_win ? bus.lsu_width : 3'b010;
          t_a  = lsu_win ? bus.lsu_addr : bus.if_addr;
          t_wd = lsu_win ? bus.lsu_wdata : 32'h0;
        end
      end
      total++;
      if (bus.busy !== in_txn) begin
        bad++; $display("FAIL rt_busy: got %b want %b", bus.busy, in_txn);
      end
      done_now = exp_done;
      total++;
      if ({bus.if_done, bus.lsu_done} !== {done_now && !cur_lsu, done_now && cur_lsu}) begin
        bad++; $display("FAIL rt_done: if_done=%b lsu_done=%b want %b %b", bus.if_done, bus.lsu_done,
                        done_now && !cur_lsu, done_now && cur_lsu);
      end
      total++;
      if ({bus.if_rdata, bus.lsu_rdata} !== {exp_if_rd, exp_lsu_rd}) begin
        bad++; $display("FAIL rt_rdata: if=%h lsu=%h want %h %h", bus.if_rdata, bus.lsu_rdata, exp_if_rd, exp_lsu_rd);
      end
      if (done_now) begin
        exp_done = 0; in_txn = 0;
        if (cur_lsu) begin lsu_out = 0; bus.lsu_req = 1'b0; end
        else begin if_out = 0; bus.if_req = 1'b0; end
      end
      // Memory side.
      if (in_txn) begin
        total++;
        if ({bus.mem_req, bus.mem_we, bus.mem_width, bus.mem_addr, bus.mem_wdata} !== {1'b1, t_we, t_w, t_a, t_wd}) begin
          bad++; $display("FAIL rt_mem_attr: req=%b we=%b w=%b a=%h wd=%h want 1 %b %b %h %h", bus.mem_req, bus.mem_we,
                          bus.mem_width, bus.mem_addr, bus.mem_wdata, t_we, t_w, t_a, t_wd);
        end
        if (mem_dly == 0) begin
          bus.mem_ready = 1'b1;
          if (t_we) begin
            mem_m[t_a] = t_wd;
            bus.mem_rdata = $urandom;
          end else begin
            bus.mem_rdata = mem_rd(t_a);
            if (cur_lsu) exp_lsu_rd = bus.mem_rdata;
            else exp_if_rd = bus.mem_rdata;
          end
          exp_done = 1;
        end else begin
          mem_dly--;
          bus.mem_ready = 1'b0;
          bus.mem_rdata = $urandom;
        end
      end else begin
        total++;
        if (bus.mem_req !== 1'b0) begin
          bad++; $display("FAIL rt_mem_idle: mem_req=%b want 0", bus.mem_req);
        end
        bus.mem_ready = 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
      // Requesters: the owner may let go of req mid-transaction; idle requesters may start a new one.
      if (drops && in_txn && ($urandom_range(0, 3) == 0)) begin
        if (cur_lsu) bus.lsu_req = 1'b0;
        else bus.if_req = 1'b0;
      end
      if (issue && !if_out && (int'($urandom_range(0, 99)) < p_if)) begin
        if_out = 1; bus.if_req = 1'b1;
        bus.if_addr = 32'h1000 + ($urandom_range(0, 15) << 2);
      end
      if (issue && !lsu_out && (int'($urandom_range(0, 99)) < p_lsu)) begin
        lsu_out = 1; bus.lsu_req = 1'b1;
        bus.lsu_we    = 1'($urandom_range(0, 1));
        bus.lsu_addr  = 32'h1000 + ($urandom_range(0, 15) << 2);
        bus.lsu_wdata = $urandom;
        bus.lsu_width = 3'($urandom_range(0, 7));
      end
      prev_busy = bus.busy;
    end
    total++;
    if ({if_out, lsu_out, in_txn} !== 3'b000) begin
      bad++; $display("FAIL rt_drain: outstanding if=%b lsu=%b txn=%b after cycle budget", if_out, lsu_out, in_txn);
    end
  endtask

  task automatic test_starvation();
    do_reset();
    run_traffic(150, 100, 100, 1'b0);
    total++;
    if (grant_log.size() < 10) begin
      bad++; $display("FAIL starve_count: got %0d grants want at least 10", grant_log.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        total++;
        if (grant_log[i] !== ((i % 5) != 4)) begin
          bad++; $display("FAIL starve_order: grant %0d lsu=%b want %b", i, grant_log[i], (i % 5) != 4);
        end
      end
    end
  endtask

  task automatic test_random();
    int n_if, n_lsu;
    do_reset();
    run_traffic(4000, 35, 45, 1'b1);
    n_if = 0; n_lsu = 0;
    foreach (grant_log[i]) begin
      if (grant_log[i]) n_lsu++;
      else n_if++;
    end
    total++;
    if ((n_if > 0 && n_lsu > 0) !== 1'b1) begin
      bad++; $display("FAIL random_mix: if grants=%0d lsu grants=%0d want both nonzero", n_if, n_lsu);
    end
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic serve_one(bit lsu, logic [31:0] a);
    bit seen;
    seen = 0;
    if (lsu) begin
      bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = a; bus.lsu_width = 3'b010;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = a;
    end
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      cy();
      if (bus.if_done | bus.lsu_done) begin
        seen = 1; bus.if_req = 1'b0; bus.lsu_req = 1'b0;
      end
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL stats_serve_timeout: no done for addr %h", a);
    end
    cy();
  endtask

  task automatic test_stats();
    do_reset();
    serve_one(1'b0, 32'h10);
    serve_one(1'b1, 32'h20);
    serve_one(1'b0, 32'h14);
    serve_one(1'b1, 32'h24);
    serve_one(1'b0, 32'h18);
    total++;
    if ({if_grant_cnt, lsu_grant_cnt} !== {32'd3, 32'd2}) begin
      bad++; $display("FAIL stats_grants: if=%0d lsu=%0d want 3 2", if_grant_cnt, lsu_grant_cnt);
    end
    total++;
    if (if_stall_cnt !== 32'd6) begin
      bad++; $display("FAIL stats_stall: got %0d want 6", if_stall_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_reset_mid();
    test_starvation();
    test_random();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port data/instruction memory between instruction fetch (IF) and the load/store unit (LSU) of the RISC-V core.
- Runs a request/done handshake with each requester and a req/ready handshake with memory.
- LSU has priority. A starvation counter guarantees IF forward progress.
- Sits between the fetch stage and the LSU on one side and the memory wrapper on the other.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_WAIT, 4, consecutive LSU grants while IF waits before IF is forced; range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  IF read request; held until if_done
- if_addr  in  ADDR_W  fetch address
- if_done  out  1  one-cycle completion pulse to IF
- if_rdata  out  DATA_W  fetched word; valid with if_done, held until next IF completion
- lsu_req  in  1  LSU request; held until lsu_done
- lsu_we  in  1  1 = store, 0 = load
- lsu_addr  in  ADDR_W  effective address
- lsu_wdata  in  DATA_W  store data
- lsu_width  in  3  funct3 access width code
- lsu_done  out  1  one-cycle completion pulse to LSU
- lsu_rdata  out  DATA_W  load data; valid with lsu_done, held until next LSU completion
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_width  out  3  access width code
- mem_ready  in  1  memory completes the transaction in this cycle
- mem_rdata  in  DATA_W  read data; valid when mem_ready=1
- busy  out  1  state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous, active-high.
- Reset values:
  - state = IDLE.
  - mem_req, mem_we, if_done, lsu_done, busy = 0.
  - mem_addr, mem_wdata, mem_width, if_rdata, lsu_rdata = 0.
  - Wait counter = 0.
- States: IDLE, MEM_IF, MEM_LSU, RESP.
- IDLE, request evaluation:
  - lsu_req=1 and (if_req=0 or wait counter < MAX_WAIT) -> MEM_LSU.
  - Otherwise, if if_req=1 -> MEM_IF.
  - On MEM_LSU entry, register lsu_addr, lsu_wdata, lsu_we and lsu_width into the mem_* outputs.
  - On MEM_IF entry, register if_addr, set mem_we=0, mem_width=3'b010, mem_wdata=0.
- Wait counter:
  - On an LSU grant with if_req=1, increment, saturating at MAX_WAIT.
  - On an IF grant, or an LSU grant with if_req=0, clear to 0.
- MEM_IF / MEM_LSU:
  - mem_req=1 with stable attributes until mem_ready=1 is sampled.
  - In that cycle capture mem_rdata into the owner's rdata register (loads/fetches only; stores leave lsu_rdata unchanged).
  - Move to RESP with mem_req=0.
- RESP:
  - Assert the owner's done for exactly one cycle, then return to IDLE.
  - Requests are not sampled in RESP. The requester drops or updates req during this cycle.
- Latency and throughput:
  - req sampled in cycle 0 -> mem_req cycle 1 -> mem_ready in cycle k >= 1 -> done in cycle k+1.
  - Peak throughput is one transaction per 3 cycles.
- mem_ready while mem_req=0 is ignored.
- A requester dropping req mid-transaction does not abort it; done still pulses.
- rst mid-transaction: the transaction is abandoned, all outputs return to reset values next cycle, and no done pulse is issued.
- Never more than one of if_done / lsu_done high. mem_req is never high in IDLE or RESP.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- When defined, adds three output ports, each a 32-bit wrapping counter cleared by rst:
  - if_grant_cnt: incremented on each IF grant.
  - lsu_grant_cnt: incremented on each LSU grant.
  - if_stall_cnt: incremented every cycle with if_req=1 and if_done=0.
- When undefined, the ports and counters do not exist and the rest of the behaviour is identical.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, memory ready 2 cycles after mem_req -> mem_addr=0x100, mem_we=0, mem_width=3'b010; if_done pulses 1 cycle later; if_rdata = mem_rdata.
- Store: lsu_req=1, we=1, addr=0x200, wdata=0xDEADBEEF, width=3'b000, ready immediately -> mem_* match; lsu_done at cycle 2; lsu_rdata unchanged.
- Simultaneous requests in IDLE with counter 0 -> LSU granted first; IF served after lsu_done.
- Starvation with MAX_WAIT=4: if_req held, lsu_req re-asserted after every done -> exactly 4 LSU grants, then 1 IF grant, then the counter restarts.
- Reset while mem_req=1 before mem_ready -> next cycle mem_req=0, busy=0, no done pulse; a new if_req is then served normally.
- With MEM_ARB_STATS_EN: 3 fetches + 2 loads -> if_grant_cnt=3, lsu_grant_cnt=2.
